// File: rtl/dram_resp.sv
// dram_resp: memory-side responder for the accelerator DRAM port.
//   Engine channel : eng_en_rd/eng_addr_rd -> eng_rdata/eng_valid one cycle later;
//                    eng_en_wr/eng_addr_wr/eng_wdata written at end of cycle.
//   Host channel   : host_req/host_we/host_addr/host_wdata -> host_ack/host_rdata
//                    one cycle later; only served while the host owns memory.
//   Ownership      : eng_start hands memory to the engine, eng_done returns it
//                    via a single flush cycle. busy = engine owns memory.
//   Status         : err (sticky protocol/range error), rd_cnt/wr_cnt engine
//                    access counters cleared on eng_start.
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_WORDS  = 262144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  eng_en_rd,
  input  logic [ADDR_WIDTH-1:0] eng_addr_rd,
  input  logic                  eng_en_wr,
  input  logic [ADDR_WIDTH-1:0] eng_addr_wr,
  input  logic [DATA_WIDTH-1:0] eng_wdata,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  eng_valid,
  input  logic                  eng_start,
  input  logic                  eng_done,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // One bit wider than the address so MEM_WORDS == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEM_WORDS);

  typedef enum logic [1:0] {ST_HOST, ST_ENG, ST_FLUSH} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

  logic rd_ok, wr_ok, host_ok;
  logic eng_rd_go, eng_wr_go, host_go, start_go;
  logic proto_err, range_err;
  logic [IDX_W-1:0] idx_rd, idx_wr, idx_host;

  assign rd_ok    = {1'b0, eng_addr_rd} < MEM_LIM;
  assign wr_ok    = {1'b0, eng_addr_wr} < MEM_LIM;
  assign host_ok  = {1'b0, host_addr}   < MEM_LIM;
  assign idx_rd   = eng_addr_rd[IDX_W-1:0];
  assign idx_wr   = eng_addr_wr[IDX_W-1:0];
  assign idx_host = host_addr[IDX_W-1:0];

  assign eng_rd_go = (state == ST_ENG)  && eng_en_rd;
  assign eng_wr_go = (state == ST_ENG)  && eng_en_wr;
  assign host_go   = (state == ST_HOST) && host_req;
  assign start_go  = (state == ST_HOST) && eng_start;

  assign busy = (state != ST_HOST);

  // Requests arriving in the wrong ownership state are dropped and flagged.
  // A host request outside ST_HOST is simply stalled, not an error.
  assign proto_err = (eng_done  && (state != ST_ENG))  ||
                     (eng_start && (state != ST_HOST)) ||
                     ((eng_en_rd || eng_en_wr) && (state != ST_ENG));
  assign range_err = (eng_rd_go && !rd_ok) || (eng_wr_go && !wr_ok) ||
                     (host_go && !host_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HOST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOST:  if (eng_start) state_nxt = ST_ENG;
      ST_ENG:   if (eng_done)  state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_HOST;
      default:  state_nxt = ST_HOST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_rdata  <= '0;
      eng_valid  <= 1'b0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
      err        <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      eng_valid <= eng_rd_go;
      host_ack  <= host_go;
      if (eng_rd_go) begin
        // Write-first: a same-cycle write to the read address is forwarded.
        if (!rd_ok)                                          eng_rdata <= '0;
        else if (eng_wr_go && wr_ok && eng_addr_wr == eng_addr_rd) eng_rdata <= eng_wdata;
        else                                                 eng_rdata <= mem[idx_rd];
      end
      if (host_go && !host_we)
        host_rdata <= host_ok ? mem[idx_host] : '0;
      // Errors raised in the start cycle itself survive the clear.
      err <= (start_go ? 1'b0 : err) | proto_err | range_err;
      if (start_go) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (eng_rd_go) rd_cnt <= rd_cnt + 32'd1;
        if (eng_wr_go) wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

  // Array is deliberately not reset so preloaded contents survive rst.
  // Engine and host writes live in disjoint ownership states.
  always_ff @(posedge clk) begin
    if (eng_wr_go && wr_ok)
      mem[idx_wr] <= eng_wdata;
    else if (host_go && host_we && host_ok)
      mem[idx_host] <= host_wdata;
  end

endmodule
